line_arbiter_adaptor: RTL and testbench
=======================================

LINE_ARBITER_ADAPTOR -- requirements
Module: line_arbiter_adaptor

Interface
REQ-001 SHALL have parameter NPORTS, default 2: number of line requesters (2..8).
REQ-002 SHALL have parameter LINE_W, default 256: cacheline width in bits.
REQ-003 SHALL have parameter BURST_W, default 64: memory beat width; BEATS = LINE_W/BURST_W, a power of two of at least 2.
REQ-004 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-005 SHALL have parameter PRIO_MODE, default 0: 0 selects round-robin, 1 selects fixed priority (port 0 highest).
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port req_read, input, NPORTS: per-port line read request.
REQ-009 SHALL have port req_write, input, NPORTS: per-port line write request.
REQ-010 SHALL have port req_address, input, NPORTS*ADDR_W: per-port address; port k occupies slice [k*ADDR_W +: ADDR_W].
REQ-011 SHALL have port req_wdata, input, NPORTS*LINE_W: per-port write line, sliced the same way.
REQ-012 SHALL have port req_rdata, output, LINE_W: assembled read line, shared by all ports.
REQ-013 SHALL have port req_resp, output, NPORTS: one-hot completion pulse.
REQ-014 SHALL have port address_o, output, ADDR_W: memory address, line-aligned.
REQ-015 SHALL have port read_o, output, 1: memory read strobe.
REQ-016 SHALL have port write_o, output, 1: memory write strobe.
REQ-017 SHALL have port burst_o, output, BURST_W: write beat data.
REQ-018 SHALL have port burst_i, input, BURST_W: read beat data.
REQ-019 SHALL have port resp_i, input, 1: memory beat-valid/accept.
REQ-020 SHALL have port busy_o, output, 1: transaction in flight.
REQ-021 SHALL have port grant_o, output, clog2(NPORTS): index of the port being serviced.

Function
REQ-022 SHALL implement FSM states IDLE, XFER, RESP; IDLE goes to XFER when any request is present, XFER goes to RESP on the final beat, RESP goes to IDLE unconditionally.
REQ-023 SHALL, in IDLE, select one requesting port and latch its index, op, address (low clog2(LINE_W/8) bits forced to 0) and wdata.
REQ-024 SHALL treat a port asserting both req_read and req_write as a write.
REQ-025 SHALL, in round-robin mode, search from rr_ptr upward with wrap and set rr_ptr = (grant+1) mod NPORTS on entering RESP.
REQ-026 SHALL, in fixed mode, grant the lowest-index requester; starvation of higher-index ports is permitted.
REQ-027 SHALL hold read_o or write_o, address_o and grant_o stable throughout XFER, with busy_o = 1 in XFER and RESP.
REQ-028 SHALL advance a beat counter on each XFER cycle with resp_i = 1; read beat k is stored at req_rdata[k*BURST_W +: BURST_W].
REQ-029 SHALL drive burst_o with write-line beat k, advancing only after a resp_i cycle; beat 0 is presented on entry to XFER.
REQ-030 SHALL take XFER to RESP on the cycle carrying resp_i for beat BEATS-1, and drop read_o/write_o in RESP.
REQ-031 SHALL pulse req_resp[grant] high for exactly one cycle in RESP, with req_rdata valid; req_rdata SHALL hold until the next read's first beat.
REQ-032 SHALL NOT sample requests during RESP; requesters deassert in the cycle after req_resp.
REQ-033 SHALL ignore resp_i outside XFER.
REQ-034 SHALL give minimum latency, request in IDLE at cycle t with resp_i on every cycle: strobe at t+1, req_resp at t+BEATS+1.
REQ-035 SHALL, in round-robin mode, serve a continuously requesting port within NPORTS transactions.
REQ-036 SHALL reject at elaboration any LINE_W not a multiple of BURST_W, or NPORTS < 2.

Reset
REQ-037 SHALL, on reset_n low, asynchronously force FSM = IDLE, rr_ptr = 0, beat counter = 0, and all outputs 0 including req_rdata.
REQ-038 SHALL, on reset during XFER, abandon the transaction with no req_resp; the next request restarts at beat 0.

Verification
REQ-039 SHALL cover: reset_n low mid-idle -> all outputs 0 immediately, busy_o = 0.
REQ-040 SHALL cover: NPORTS=2, port1 read at 0x0000_1234 -> address_o = 0x0000_1220 and read_o the next cycle; beats 0xA..,0xB..,0xC..,0xD.. -> req_rdata = {D,C,B,A} and req_resp = 2'b10 for one cycle.
REQ-041 SHALL cover: round-robin, rr_ptr = 0, port0 write and port1 read simultaneous -> port0 served (burst_o beats 0..3 in order), then port1; rr_ptr returns to 0.
REQ-042 SHALL cover: fixed mode, port0 re-requesting every IDLE -> port1 never granted; round-robin same stimulus -> grants alternate 0,1,0,1.
REQ-043 SHALL cover: reset_n pulsed after 2 read beats -> read_o low at once, no req_resp; a re-issued read completes with 4 fresh beats.
REQ-044 SHALL cover: resp_i high for 3 cycles in IDLE -> no state change, no req_resp.

Source files
------------

// File: rtl/line_arbiter_adaptor.sv
// Arbitrates NPORTS cacheline requesters onto a single burst memory port,
// splitting each line into BEATS beats and reassembling read lines.
module line_arbiter_adaptor #(
    parameter int NPORTS    = 2,
    parameter int LINE_W    = 256,
    parameter int BURST_W   = 64,
    parameter int ADDR_W    = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NPORTS-1:0]           req_read,
    input  logic [NPORTS-1:0]           req_write,
    input  logic [NPORTS*ADDR_W-1:0]    req_address,
    input  logic [NPORTS*LINE_W-1:0]    req_wdata,
    output logic [LINE_W-1:0]           req_rdata,
    output logic [NPORTS-1:0]           req_resp,
    output logic [ADDR_W-1:0]           address_o,
    output logic                        read_o,
    output logic                        write_o,
    output logic [BURST_W-1:0]          burst_o,
    input  logic [BURST_W-1:0]          burst_i,
    input  logic                        resp_i,
    output logic                        busy_o,
    output logic [$clog2(NPORTS)-1:0]   grant_o
);

    localparam int BEATS  = LINE_W / BURST_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int GNT_W  = $clog2(NPORTS);
    localparam int OFF_W  = $clog2(LINE_W / 8);

    generate
        if (NPORTS < 2 || NPORTS > 8 || (LINE_W % BURST_W) != 0 ||
            BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_cfg
            $error("line_arbiter_adaptor: unsupported NPORTS/LINE_W/BURST_W combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t              state, state_nxt;
    logic [NPORTS-1:0]   req_any;
    logic [GNT_W-1:0]    sel, cand, grant_q, rr_ptr;
    logic                sel_vld;
    logic                op_write_q;
    logic [ADDR_W-1:0]   sel_addr, addr_q;
    logic [LINE_W-1:0]   wdata_q, rdata_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                last_beat;

    assign req_any   = req_read | req_write;
    assign sel_addr  = req_address[sel*ADDR_W +: ADDR_W];
    assign last_beat = (state == XFER) && resp_i && (beat_q == BEAT_W'(BEATS - 1));

    // Search order starts at rr_ptr (round-robin) or port 0 (fixed priority).
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (PRIO_MODE == 1)
                cand = GNT_W'(i);
            else
                cand = GNT_W'((int'(rr_ptr) + i) % NPORTS);
            if (!sel_vld && req_any[cand]) begin
                sel_vld = 1'b1;
                sel     = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_vld) state_nxt = XFER;
            XFER:    if (last_beat) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q    <= '0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            beat_q     <= '0;
            rr_ptr     <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        grant_q    <= sel;
                        op_write_q <= req_write[sel];
                        addr_q     <= {sel_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        beat_q     <= '0;
                    end
                end
                XFER: begin
                    if (resp_i) begin
                        beat_q <= beat_q + BEAT_W'(1);
                        if (!op_write_q)
                            rdata_q[beat_q*BURST_W +: BURST_W] <= burst_i;
                        if (last_beat)
                            rr_ptr <= (grant_q == GNT_W'(NPORTS - 1)) ? '0 : grant_q + GNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Write line is pure data; burst_o is gated so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && sel_vld)
            wdata_q <= req_wdata[sel*LINE_W +: LINE_W];
    end

    assign busy_o    = (state != IDLE);
    assign read_o    = (state == XFER) && !op_write_q;
    assign write_o   = (state == XFER) && op_write_q;
    assign address_o = addr_q;
    assign grant_o   = grant_q;
    assign burst_o   = write_o ? wdata_q[beat_q*BURST_W +: BURST_W] : '0;
    assign req_rdata = rdata_q;
    assign req_resp  = (state == RESP) ? (NPORTS'(1) << grant_q) : '0;

endmodule

// File: tb/tb_line_arbiter_adaptor.sv
// Bench for line_arbiter_adaptor: round-robin and fixed-priority instances share
// stimulus; a transaction-level model predicts grants, beats and lines.
module tb_line_arbiter_adaptor;

    localparam int NP = 2, LW = 256, BW = 64, AW = 32, BEATS = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NP-1:0]     req_read, req_write;
    logic [NP*AW-1:0]  req_address;
    logic [NP*LW-1:0]  req_wdata;
    logic [BW-1:0]     burst_i;
    logic              resp_i;

    logic [LW-1:0] req_rdata, f_req_rdata;
    logic [NP-1:0] req_resp, f_req_resp;
    logic [AW-1:0] address_o, f_address_o;
    logic          read_o, f_read_o, write_o, f_write_o, busy_o, f_busy_o;
    logic [BW-1:0] burst_o, f_burst_o;
    logic          grant_o, f_grant_o;

    int            n_vec = 0, n_err = 0;
    int            rr_m;
    logic [LW-1:0] last_rd, f_last_rd;

    always #5 clk = ~clk;

    line_arbiter_adaptor #(.NPORTS(NP), .LINE_W(LW), .BURST_W(BW), .ADDR_W(AW), .PRIO_MODE(0)) dut_rr (
        .clk(clk), .reset_n(reset_n), .req_read(req_read), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata), .req_rdata(req_rdata),
        .req_resp(req_resp), .address_o(address_o), .read_o(read_o), .write_o(write_o),
        .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i), .busy_o(busy_o), .grant_o(grant_o));

    line_arbiter_adaptor #(.NPORTS(NP), .LINE_W(LW), .BURST_W(BW), .ADDR_W(AW), .PRIO_MODE(1)) dut_fx (
        .clk(clk), .reset_n(reset_n), .req_read(req_read), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata), .req_rdata(f_req_rdata),
        .req_resp(f_req_resp), .address_o(f_address_o), .read_o(f_read_o), .write_o(f_write_o),
        .burst_o(f_burst_o), .burst_i(burst_i), .resp_i(resp_i), .busy_o(f_busy_o), .grant_o(f_grant_o));

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_rdata"}, req_rdata, '0);
        check({tag, "_resp"}, LW'(req_resp), '0);
        check({tag, "_addr"}, LW'(address_o), '0);
        check({tag, "_strobe"}, LW'({read_o, write_o}), '0);
        check({tag, "_burst"}, LW'(burst_o), '0);
        check({tag, "_busy"}, LW'(busy_o), '0);
        check({tag, "_grant"}, LW'(grant_o), '0);
        check({tag, "_f_all"}, LW'({f_req_resp, f_read_o, f_write_o, f_busy_o, f_grant_o}), '0);
        check({tag, "_f_data"}, LW'(f_address_o) | LW'(f_burst_o) | f_req_rdata, '0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, LW'({busy_o, f_busy_o}), '0);
        check({tag, "_resp"}, LW'({req_resp, f_req_resp}), '0);
        check({tag, "_strobe"}, LW'({read_o, write_o, f_read_o, f_write_o}), '0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_zero("reset");
        tick;
        reset_n   = 1'b1;
        rr_m      = 0;
        last_rd   = '0;
        f_last_rd = '0;
        tick;
    endtask

    // One complete transaction: requests offered for one IDLE cycle, then the
    // memory side answers beats with probability pct percent per cycle.
    task automatic do_txn(input logic [NP-1:0] rd, input logic [NP-1:0] wr,
                          input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [LW-1:0] w0, input logic [LW-1:0] w1,
                          input logic [LW-1:0] rline, input int pct);
        logic [NP-1:0] req;
        int            g, gf, beat, cyc;
        logic          wr_g, wr_f;
        logic [AW-1:0] ea, ea_f;
        logic [LW-1:0] ew, ew_f;
        req = rd | wr;
        g   = -1;
        gf  = -1;
        for (int i = 0; i < NP; i++) begin
            int k;
            k = (rr_m + i) % NP;
            if (g < 0 && req[k]) g = k;
            if (gf < 0 && req[i]) gf = i;
        end
        wr_g = wr[g];
        wr_f = wr[gf];
        ea   = ((g == 1) ? a1 : a0) & ~32'h1F;
        ea_f = ((gf == 1) ? a1 : a0) & ~32'h1F;
        ew   = (g == 1) ? w1 : w0;
        ew_f = (gf == 1) ? w1 : w0;

        req_read    = rd;
        req_write   = wr;
        req_address = {a1, a0};
        req_wdata   = {w1, w0};
        tick;
        req_read  = '0;
        req_write = '0;

        beat = 0;
        cyc  = 0;
        while (beat < BEATS && cyc < 300) begin
            check("busy_xfer", LW'({busy_o, f_busy_o}), LW'(2'b11));
            check("strobe", LW'({read_o, write_o}), LW'({!wr_g, wr_g}));
            check("f_strobe", LW'({f_read_o, f_write_o}), LW'({!wr_f, wr_f}));
            check("address_o", LW'(address_o), LW'(ea));
            check("f_address_o", LW'(f_address_o), LW'(ea_f));
            check("grant_o", LW'(grant_o), LW'(g));
            check("f_grant_o", LW'(f_grant_o), LW'(gf));
            check("resp_early", LW'({req_resp, f_req_resp}), '0);
            if (wr_g) check("burst_o", LW'(burst_o), LW'(ew[beat*BW +: BW]));
            if (wr_f) check("f_burst_o", LW'(f_burst_o), LW'(ew_f[beat*BW +: BW]));
            resp_i  = ($urandom_range(99) < pct);
            burst_i = resp_i ? rline[beat*BW +: BW] : {$urandom, $urandom};
            tick;
            if (resp_i) beat++;
            cyc++;
        end
        resp_i  = 1'b0;
        burst_i = '0;
        if (beat < BEATS) check("beat_timeout", LW'(beat), LW'(BEATS));

        if (!wr_g) last_rd = rline;
        if (!wr_f) f_last_rd = rline;
        check("req_resp", LW'(req_resp), LW'(1 << g));
        check("f_req_resp", LW'(f_req_resp), LW'(1 << gf));
        check("busy_resp", LW'({busy_o, f_busy_o}), LW'(2'b11));
        check("strobe_resp", LW'({read_o, write_o, f_read_o, f_write_o}), '0);
        check("req_rdata", req_rdata, last_rd);
        check("f_req_rdata", f_req_rdata, f_last_rd);
        rr_m = (g + 1) % NP;
        tick;
        check_idle("after_resp");
        check("rdata_hold", req_rdata, last_rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] line_abcd;
        logic [NP-1:0] rd, wr;
        req_read = '0; req_write = '0; req_address = '0; req_wdata = '0;
        burst_i = '0; resp_i = 1'b0;
        reset_n = 1'b0;
        #3;
        check_zero("por");
        tick;
        do_reset();

        // Port1 read, address aligned, {D,C,B,A} assembled
        line_abcd = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                     64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        do_txn(2'b10, 2'b00, $urandom, 32'h0000_1234, rand_line(), rand_line(), line_abcd, 100);

        // Reset mid-idle clears everything including the read line
        do_reset();

        // Simultaneous port0 write / port1 read; then port1; rr back to 0
        do_txn(2'b10, 2'b01, $urandom, $urandom, rand_line(), rand_line(), rand_line(), 100);
        do_txn(2'b10, 2'b00, $urandom, $urandom, rand_line(), rand_line(), rand_line(), 100);
        do_txn(2'b11, 2'b00, $urandom, $urandom, rand_line(), rand_line(), rand_line(), 100);

        // Both ports requesting every IDLE: rr alternates, fixed stays on 0
        for (int i = 0; i < 4; i++)
            do_txn(2'b11, {1'b0, i[0]}, $urandom, $urandom, rand_line(), rand_line(), rand_line(), 70);

        // resp_i in IDLE has no effect
        resp_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check_idle("idle_resp");
        end
        resp_i = 1'b0;
        do_txn(2'b01, 2'b00, $urandom, $urandom, rand_line(), rand_line(), rand_line(), 100);

        // Reset after two read beats abandons the transaction
        req_read    = 2'b01;
        req_address = {$urandom, $urandom};
        tick;
        req_read = '0;
        resp_i   = 1'b1;
        burst_i  = {$urandom, $urandom};
        tick;
        tick;
        check("pre_reset_read", LW'(read_o), LW'(1));
        do_reset();
        resp_i = 1'b0;
        check_idle("post_abort");
        do_txn(2'b01, 2'b00, $urandom, $urandom, rand_line(), rand_line(), rand_line(), 100);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            int idle;
            idle = $urandom_range(2);
            for (int c = 0; c < idle; c++) begin
                resp_i = $urandom_range(1) == 1;
                tick;
                check_idle("rand_idle");
            end
            resp_i = 1'b0;
            rd = NP'($urandom);
            wr = NP'($urandom);
            if ((rd | wr) == '0) rd = 2'b01;
            do_txn(rd, wr, $urandom, $urandom, rand_line(), rand_line(), rand_line(),
                   int'($urandom_range(100, 25)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
